// File: rtl/ma_stage.sv
// ---------------------------------------------------------------------------
// ma_stage : memory-access pipeline stage
//
// This stage takes the registered EX/MA bundle and does one of two things:
//   - non-memory ops pass straight to the MA/RW register with 1-cycle latency
//   - ld/st ops issue one data-memory access over a req/ack handshake
// While an access is in flight the stage stalls EX by holding ex_ma_ready low.
// If no ack arrives within ACK_TIMEOUT request cycles, the access is aborted
// and an error bubble (valid=1, err=1) goes to writeback.
//
// Optional feature (compile-time macro MA_ALIGN_CHECK_EN):
//   When defined, a ld/st whose address is not word aligned issues no
//   request. It goes straight to MA/RW with err=1 and result=address.
//   When undefined, addresses are issued unchanged.
//
// Parameters:
//   DATA_W       width of pc / alu result / store data / instr / mem data
//   ACK_TIMEOUT  request cycles allowed before abort (1..255)
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ex_ma_*                EX/MA bundle in, ex_ma_ready back-pressure out
//   dmem_req/we/addr/wdata memory request out (stable until ack or abort)
//   dmem_rdata, dmem_ack   memory response in
//   ma_rw_*                registered MA/RW bundle out
// ---------------------------------------------------------------------------
module ma_stage #(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ex_ma_valid,
    output logic              ex_ma_ready,
    input  logic [DATA_W-1:0] ex_ma_pc,
    input  logic [DATA_W-1:0] ex_ma_alu_result,
    input  logic [DATA_W-1:0] ex_ma_op2,
    input  logic [DATA_W-1:0] ex_ma_instr,
    input  logic              ex_ma_is_ld,
    input  logic              ex_ma_is_st,
    input  logic              ex_ma_is_wb,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,

    output logic              ma_rw_valid,
    output logic [DATA_W-1:0] ma_rw_pc,
    output logic [DATA_W-1:0] ma_rw_instr,
    output logic [DATA_W-1:0] ma_rw_result,
    output logic              ma_rw_is_wb,
    output logic              ma_rw_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // An 8-bit counter covers the whole legal ACK_TIMEOUT range.
    localparam int              CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    // Memory op captured at accept time; it drives the request while in REQ.
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              st;
        logic              wb;
    } mem_op_t;

    // MA/RW pipeline register.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] result;
        logic              is_wb;
        logic              err;
    } rw_t;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    mem_op_t          op_q,    op_d;
    rw_t              rw_q,    rw_d;

    logic accept;
    logic is_mem;
    logic align_fault;

    assign accept = ex_ma_valid & ex_ma_ready;
    assign is_mem = ex_ma_is_ld | ex_ma_is_st;

`ifdef MA_ALIGN_CHECK_EN
    assign align_fault = |ex_ma_alu_result[1:0];
`else
    assign align_fault = 1'b0;
`endif

    // Ready depends only on state, but is also forced low while reset is
    // held so EX never sees an accept during reset.
    assign ex_ma_ready = rst_n & (state_q == ST_IDLE);

    // Request fields are zero outside REQ so the bus is quiet when idle.
    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = dmem_req & op_q.st;
    assign dmem_addr  = dmem_req ? op_q.addr  : '0;
    assign dmem_wdata = dmem_req ? op_q.wdata : '0;

    assign ma_rw_valid  = rw_q.valid;
    assign ma_rw_pc     = rw_q.pc;
    assign ma_rw_instr  = rw_q.instr;
    assign ma_rw_result = rw_q.result;
    assign ma_rw_is_wb  = rw_q.is_wb;
    assign ma_rw_err    = rw_q.err;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rw_d     = rw_q;
        // MA/RW is a bubble unless something completes this cycle; the
        // payload fields hold their last value.
        rw_d.valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mem && align_fault) begin
                        rw_d.valid  = 1'b1;
                        rw_d.pc     = ex_ma_pc;
                        rw_d.instr  = ex_ma_instr;
                        rw_d.result = ex_ma_alu_result;
                        rw_d.is_wb  = 1'b0;
                        rw_d.err    = 1'b1;
                    end else if (is_mem) begin
                        op_d.pc    = ex_ma_pc;
                        op_d.instr = ex_ma_instr;
                        op_d.addr  = ex_ma_alu_result;
                        op_d.wdata = ex_ma_op2;
                        // ld+st together resolves to a load.
                        op_d.st    = ex_ma_is_st & ~ex_ma_is_ld;
                        op_d.wb    = ex_ma_is_wb;
                        cnt_d      = '0;
                        state_d    = ST_REQ;
                    end else begin
                        rw_d.valid  = 1'b1;
                        rw_d.pc     = ex_ma_pc;
                        rw_d.instr  = ex_ma_instr;
                        rw_d.result = ex_ma_alu_result;
                        rw_d.is_wb  = ex_ma_is_wb;
                        rw_d.err    = 1'b0;
                    end
                end
            end

            ST_REQ: begin
                if (dmem_ack) begin
                    // Ack wins over a timeout landing on the same cycle.
                    rw_d.valid  = 1'b1;
                    rw_d.pc     = op_q.pc;
                    rw_d.instr  = op_q.instr;
                    rw_d.result = op_q.st ? op_q.addr : dmem_rdata;
                    rw_d.is_wb  = op_q.st ? 1'b0 : op_q.wb;
                    rw_d.err    = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // This was the last allowed request cycle: abort.
                    rw_d.valid  = 1'b1;
                    rw_d.pc     = op_q.pc;
                    rw_d.instr  = op_q.instr;
                    rw_d.result = '0;
                    rw_d.is_wb  = 1'b0;
                    rw_d.err    = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rw_q    <= rw_d;
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
// ---------------------------------------------------------------------------
// tb_ma_stage : self-checking bench for ma_stage.
// A transaction-level model (pending op + wait count + expected MA/RW) is
// stepped on every clock edge. The DUT is compared against it at each
// negedge. Directed scenarios add literal expectations on top of the model,
// and a randomized phase then exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_ma_stage;

    localparam int W   = 32;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_ma_valid, ex_ma_ready;
    logic [W-1:0]  ex_ma_pc, ex_ma_alu_result, ex_ma_op2, ex_ma_instr;
    logic          ex_ma_is_ld, ex_ma_is_st, ex_ma_is_wb;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic          ma_rw_valid, ma_rw_is_wb, ma_rw_err;
    logic [W-1:0]  ma_rw_pc, ma_rw_instr, ma_rw_result;

    always #5 clk = ~clk;

    ma_stage #(.DATA_W(W), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_ma_valid(ex_ma_valid), .ex_ma_ready(ex_ma_ready),
        .ex_ma_pc(ex_ma_pc), .ex_ma_alu_result(ex_ma_alu_result),
        .ex_ma_op2(ex_ma_op2), .ex_ma_instr(ex_ma_instr),
        .ex_ma_is_ld(ex_ma_is_ld), .ex_ma_is_st(ex_ma_is_st), .ex_ma_is_wb(ex_ma_is_wb),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .ma_rw_valid(ma_rw_valid), .ma_rw_pc(ma_rw_pc), .ma_rw_instr(ma_rw_instr),
        .ma_rw_result(ma_rw_result), .ma_rw_is_wb(ma_rw_is_wb), .ma_rw_err(ma_rw_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural model ----------------
    bit           m_busy;
    int           m_wait;       // request cycles already spent without ack
    int           cur_delay;    // memory answers when m_wait reaches this
    int           next_delay;   // latency handed to the next accepted access
    bit           m_st, m_wb;
    logic [W-1:0] m_pc, m_instr, m_addr, m_wdata;
    bit           e_valid, e_is_wb, e_err;
    logic [W-1:0] e_pc, e_instr, e_result;

    bit           force_ack;
    bit           fixed_rd_en;
    logic [W-1:0] fixed_rd;

    task automatic model_reset();
        m_busy = 0; m_wait = 0;
        m_st = 0; m_wb = 0; m_pc = '0; m_instr = '0; m_addr = '0; m_wdata = '0;
        e_valid = 0; e_is_wb = 0; e_err = 0; e_pc = '0; e_instr = '0; e_result = '0;
    endtask

    task automatic emit(logic [W-1:0] pc, logic [W-1:0] ins, logic [W-1:0] res,
                        bit wb, bit err);
        e_valid = 1; e_pc = pc; e_instr = ins; e_result = res; e_is_wb = wb; e_err = err;
    endtask

    // What the stage must do at a rising edge, given the inputs now applied.
    task automatic model_step();
        bit misal;
        if (!rst_n) begin model_reset(); return; end
        e_valid = 0;
        if (m_busy) begin
            if (dmem_ack) begin
                emit(m_pc, m_instr, m_st ? m_addr : dmem_rdata, m_st ? 1'b0 : m_wb, 1'b0);
                m_busy = 0;
            end else if (m_wait + 1 == TMO) begin
                emit(m_pc, m_instr, '0, 1'b0, 1'b1);
                m_busy = 0;
            end else begin
                m_wait++;
            end
        end else if (ex_ma_valid) begin
`ifdef MA_ALIGN_CHECK_EN
            misal = (ex_ma_alu_result % 4) != 0;
`else
            misal = 0;
`endif
            if ((ex_ma_is_ld || ex_ma_is_st) && misal) begin
                emit(ex_ma_pc, ex_ma_instr, ex_ma_alu_result, 1'b0, 1'b1);
            end else if (ex_ma_is_ld || ex_ma_is_st) begin
                m_busy = 1; m_wait = 0; cur_delay = next_delay;
                m_pc = ex_ma_pc; m_instr = ex_ma_instr; m_addr = ex_ma_alu_result;
                m_wdata = ex_ma_op2; m_st = ex_ma_is_st && !ex_ma_is_ld; m_wb = ex_ma_is_wb;
            end else begin
                emit(ex_ma_pc, ex_ma_instr, ex_ma_alu_result, ex_ma_is_wb, 1'b0);
            end
        end
    endtask

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("ready",     W'(ex_ma_ready), W'(!m_busy));
        chk("req",       W'(dmem_req),    W'(m_busy));
        if (m_busy) begin
            chk("we",    W'(dmem_we), W'(m_st));
            chk("addr",  dmem_addr,   m_addr);
            chk("wdata", dmem_wdata,  m_wdata);
        end
        chk("rw_valid",  W'(ma_rw_valid), W'(e_valid));
        chk("rw_pc",     ma_rw_pc,        e_pc);
        chk("rw_instr",  ma_rw_instr,     e_instr);
        chk("rw_result", ma_rw_result,    e_result);
        chk("rw_is_wb",  W'(ma_rw_is_wb), W'(e_is_wb));
        chk("rw_err",    W'(ma_rw_err),   W'(e_err));
    endtask

    // One clock: drive the memory side, step the model at the edge, compare.
    task automatic tick();
        dmem_ack   = force_ack || (m_busy && m_wait == cur_delay);
        dmem_rdata = fixed_rd_en ? fixed_rd : W'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(bit v, bit ld, bit st, bit wb, logic [W-1:0] alu, logic [W-1:0] op2);
        ex_ma_valid = v; ex_ma_is_ld = ld; ex_ma_is_st = st; ex_ma_is_wb = wb;
        ex_ma_alu_result = alu; ex_ma_op2 = op2;
        ex_ma_pc = W'($urandom); ex_ma_instr = W'($urandom);
    endtask

    task automatic idle_until_free(output int nreq);
        nreq = 0;
        drive(0, 0, 0, 0, '0, '0);
        while (dmem_req && nreq < 40) begin
            nreq++;
            tick();
        end
    endtask

    initial begin
        int n;
        rst_n = 0; force_ack = 0; fixed_rd_en = 0; fixed_rd = '0;
        next_delay = 0; cur_delay = 0;
        dmem_ack = 0; dmem_rdata = '0;
        drive(0, 0, 0, 0, '0, '0);
        model_reset();

        // reset state
        #1;
        chk("rst_ready", W'(ex_ma_ready), '0);
        chk("rst_req",   W'(dmem_req),    '0);
        chk("rst_valid", W'(ma_rw_valid), '0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        chk("post_rst_ready", W'(ex_ma_ready), 32'd1);
        @(negedge clk);
        compare();

        // four back-to-back non-memory ops
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 1, W'(i), '0);
            tick();
            chk("add_valid",  W'(ma_rw_valid), 32'd1);
            chk("add_result", ma_rw_result,    W'(i));
            chk("add_ready",  W'(ex_ma_ready), 32'd1);
        end

        // load with two wait cycles
        fixed_rd_en = 1; fixed_rd = 32'hDEADBEEF; next_delay = 2;
        drive(1, 1, 0, 1, 32'h100, '0);
        tick();
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_we",   W'(dmem_we), '0);
        idle_until_free(n);
        chk("ld_req_cycles", W'(n), 32'd3);
        chk("ld_result", ma_rw_result, 32'hDEADBEEF);
        chk("ld_is_wb",  W'(ma_rw_is_wb), 32'd1);
        fixed_rd_en = 0;

        // zero-wait store
        next_delay = 0;
        drive(1, 0, 1, 1, 32'h40, 32'h1234);
        tick();
        chk("st_we",    W'(dmem_we), 32'd1);
        chk("st_wdata", dmem_wdata, 32'h1234);
        idle_until_free(n);
        chk("st_req_cycles", W'(n), 32'd1);
        chk("st_valid", W'(ma_rw_valid), 32'd1);
        chk("st_is_wb", W'(ma_rw_is_wb), '0);
        chk("st_err",   W'(ma_rw_err), '0);

        // timeout: memory never answers
        next_delay = 1000;
        drive(1, 1, 0, 1, 32'h200, '0);
        tick();
        idle_until_free(n);
        chk("tmo_req_cycles", W'(n), W'(TMO));
        chk("tmo_valid", W'(ma_rw_valid), 32'd1);
        chk("tmo_err",   W'(ma_rw_err), 32'd1);
        chk("tmo_is_wb", W'(ma_rw_is_wb), '0);
        chk("tmo_ready", W'(ex_ma_ready), 32'd1);

        // async reset on the second request cycle
        next_delay = 1000;
        drive(1, 1, 0, 1, 32'h300, '0);
        tick();
        drive(0, 0, 0, 0, '0, '0);
        tick();
        chk("pre_rst_req", W'(dmem_req), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("arst_req",   W'(dmem_req),    '0);
        chk("arst_ready", W'(ex_ma_ready), '0);
        chk("arst_valid", W'(ma_rw_valid), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rel_ready", W'(ex_ma_ready), 32'd1);
        force_ack = 1;
        tick();
        force_ack = 0;
        chk("late_ack_req",   W'(dmem_req),    '0);
        chk("late_ack_valid", W'(ma_rw_valid), '0);

        // misaligned load
        next_delay = 0;
        drive(1, 1, 0, 1, 32'h102, '0);
        tick();
`ifdef MA_ALIGN_CHECK_EN
        chk("mis_req",    W'(dmem_req),    '0);
        chk("mis_err",    W'(ma_rw_err),   32'd1);
        chk("mis_result", ma_rw_result,    32'h102);
`else
        chk("mis_req",  W'(dmem_req), 32'd1);
        chk("mis_addr", dmem_addr,    32'h102);
        idle_until_free(n);
        chk("mis_err",  W'(ma_rw_err), '0);
`endif

        // randomized mixed traffic
        for (int c = 0; c < 3000; c++) begin
            int k;
            k = $urandom_range(0, 99);
            next_delay = ($urandom_range(0, 99) < 10) ? 1000 : $urandom_range(0, 4);
            force_ack  = !m_busy && ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 9) < 7,
                  (k >= 40 && k < 70) || k >= 95,
                  k >= 70,
                  $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? W'($urandom) : (W'($urandom) & ~32'h3),
                  W'($urandom));
            tick();
        end
        force_ack = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
